bip_tx_scheduler: RTL and testbench

- Arbitrates two 16-bit word producers onto the single byte-wide UART transmitter. Requester 0 is the BIP accumulator stream (ACC_OUT/WR_FIFO); requester 1 is the debug/status word source.
- Holds one pending word per requester and grants round-robin.
- Serialises each granted word MSB-first as bytes, using a one-cycle start pulse and a done pulse from the transmitter.
- Sits between the processor and the UART interface in the top level.

---
 rtl/bip_tx_pkg.sv | 16 +
 rtl/tx_req_buffer.sv | 30 +++
 rtl/bip_tx_scheduler.sv | 131 +++++++++++++
 tb/tb_bip_tx_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_tx_pkg.sv
// Shared types and constants for the BIP transmit scheduler.
package bip_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [3:0] HDR_TAG = 4'hA;

    function automatic int unsigned calc_bytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/tx_req_buffer.sv
// One-entry holding register for a requester word.
// A word is accepted when valid & ready; clear empties it when the word is granted.
module tx_req_buffer #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic              clear,
    output logic              ready,
    output logic              full,
    output logic [DATA_W-1:0] word
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            word <= '0;
        end else if (valid && !full) begin
            full <= 1'b1;
            word <= data;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

    assign ready = !full;

endmodule

// File: rtl/bip_tx_scheduler.sv
// Round-robin scheduler serialising two word requesters onto a byte-wide UART transmitter.
// Define BIP_TX_HEADER_EN to prefix each frame with a {HDR_TAG, 3'b000, grant} header byte.
module bip_tx_scheduler
    import bip_tx_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0_VALID,
    input  logic [DATA_W-1:0] REQ0_DATA,
    output logic              REQ0_READY,
    input  logic              REQ1_VALID,
    input  logic [DATA_W-1:0] REQ1_DATA,
    output logic              REQ1_READY,
    output logic              TX_START,
    output logic [7:0]        TX_DATA,
    input  logic              TX_DONE,
    output logic              GRANT,
    output logic              BUSY,
    output logic              ERR
);

    localparam int unsigned BYTES = calc_bytes(DATA_W);
`ifdef BIP_TX_HEADER_EN
    localparam int unsigned FRAME = BYTES + 1;
`else
    localparam int unsigned FRAME = BYTES;
`endif
    localparam int unsigned SH_W  = FRAME * 8;
    localparam int unsigned IDX_W = $clog2(FRAME + 1);
    localparam int unsigned WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME - 1);

    state_t            state, state_next;
    logic              full0, full1, clear0, clear1;
    logic [DATA_W-1:0] word0, word1, sel_word;
    logic [SH_W-1:0]   shreg, frame_word;
    logic [IDX_W-1:0]  idx;
    logic [WD_W-1:0]   wd_cnt;
    logic              last, sel, load, advance, finish, abort, wd_hit;

    tx_req_buffer #(.DATA_W(DATA_W)) u_buf0 (
        .clk(CLK), .rst_n(RESET), .valid(REQ0_VALID), .data(REQ0_DATA),
        .clear(clear0), .ready(REQ0_READY), .full(full0), .word(word0)
    );

    tx_req_buffer #(.DATA_W(DATA_W)) u_buf1 (
        .clk(CLK), .rst_n(RESET), .valid(REQ1_VALID), .data(REQ1_DATA),
        .clear(clear1), .ready(REQ1_READY), .full(full1), .word(word1)
    );

    assign wd_hit   = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT - 1));
    assign sel_word = sel ? word1 : word0;
`ifdef BIP_TX_HEADER_EN
    assign frame_word = {HDR_TAG, 3'b000, sel, sel_word};
`else
    assign frame_word = sel_word;
`endif
    assign clear0  = load && !sel;
    assign clear1  = load && sel;
    assign TX_DATA = shreg[SH_W-1 -: 8];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        sel        = (full0 && full1) ? !last : full1;
        case (state)
            IDLE: if (full0 || full1) begin
                load       = 1'b1;
                state_next = SEND;
            end
            SEND: state_next = WAIT;
            WAIT: begin
                // TX_DONE wins over a coinciding watchdog expiry
                if (TX_DONE) begin
                    if (idx == LAST_IDX) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance    = 1'b1;
                        state_next = SEND;
                    end
                end else if (wd_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        TX_START = (state == SEND);
        BUSY     = (state != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            shreg  <= '0;
            idx    <= '0;
            GRANT  <= 1'b0;
            last   <= 1'b1;
            wd_cnt <= '0;
            ERR    <= 1'b0;
        end else begin
            if (load) begin
                shreg <= frame_word;
                idx   <= '0;
                GRANT <= sel;
            end else if (advance) begin
                shreg <= shreg << 8;
                idx   <= idx + 1'b1;
            end
            if (state == SEND)      wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
            if (finish || abort) last <= GRANT;
            if (abort)           ERR  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bip_tx_scheduler.sv
// Self-checking bench for bip_tx_scheduler: table-driven frames plus latency,
// back-pressure, watchdog and mid-frame reset sequences.
module tb_bip_tx_scheduler;

    logic        CLK = 1'b0, RESET = 1'b0, TX_DONE = 1'b0;
    logic        REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic [15:0] REQ0_DATA = '0, REQ1_DATA = '0;
    logic        REQ0_READY, REQ1_READY, TX_START, GRANT, BUSY, ERR;
    logic [7:0]  TX_DATA;

    int errors = 0, checks = 0, cyc = 0;
    bit auto_done = 1'b1;
    int done_delay = 2, pending = 0;

    logic [7:0] cap_b[$], exp_b[$];
    bit         cap_g[$], exp_g[$];
    int         cap_c[$];

    typedef struct {
        bit          v0;
        logic [15:0] d0;
        bit          v1;
        logic [15:0] d1;
        bit          first;   // expected source of the first frame when both request
    } vec_t;
    vec_t vecs[6];

    bip_tx_scheduler #(.DATA_W(16), .TIMEOUT(20)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
        .TX_START(TX_START), .TX_DATA(TX_DATA), .TX_DONE(TX_DONE),
        .GRANT(GRANT), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RESET && TX_START) begin
            cap_b.push_back(TX_DATA);
            cap_g.push_back(GRANT);
            cap_c.push_back(cyc);
        end
    end

    // Transmitter model: pulses TX_DONE done_delay negedges after each start
    always @(negedge CLK) begin
        TX_DONE = 1'b0;
        if (pending > 0) begin
            pending--;
            if (pending == 0) TX_DONE = 1'b1;
        end
        if (RESET && TX_START && auto_done) pending = done_delay;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic add_frame(input bit src, input logic [15:0] w);
`ifdef BIP_TX_HEADER_EN
        exp_b.push_back({4'hA, 3'b000, src});
        exp_g.push_back(src);
`endif
        exp_b.push_back(w[15:8]); exp_g.push_back(src);
        exp_b.push_back(w[7:0]);  exp_g.push_back(src);
    endtask

    task automatic clear_q();
        cap_b.delete(); cap_g.delete(); cap_c.delete();
        exp_b.delete(); exp_g.delete();
    endtask

    task automatic compare_frames(input string name);
        check({name, " count"}, cap_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            if (i < cap_b.size()) begin
                check($sformatf("%s byte%0d", name, i), cap_b[i], exp_b[i]);
                check($sformatf("%s grant%0d", name, i), cap_g[i], exp_g[i]);
            end
        end
        clear_q();
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 600 && !ok; n++) begin
            @(negedge CLK);
            if (!BUSY && REQ0_READY && REQ1_READY) ok = 1'b1;
        end
        if (!ok) fail_now({name, " idle"});
    endtask

    task automatic push(input bit src, input logic [15:0] w);
        bit ok = 1'b0;
        @(negedge CLK);
        if (src) begin REQ1_VALID = 1'b1; REQ1_DATA = w; end
        else     begin REQ0_VALID = 1'b1; REQ0_DATA = w; end
        for (int n = 0; n < 600 && !ok; n++) begin
            if (src ? REQ1_READY : REQ0_READY) ok = 1'b1;
            else @(negedge CLK);
        end
        if (!ok) fail_now("push accept");
        @(posedge CLK);
        #1;
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
    endtask

    task automatic drive_pair(input vec_t v);
        @(negedge CLK);
        REQ0_VALID = v.v0; REQ0_DATA = v.d0;
        REQ1_VALID = v.v1; REQ1_DATA = v.d1;
        @(posedge CLK);
        #1;
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, err_cyc, n_cap;
        bit ok;

        vecs[0] = '{1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0};
        vecs[1] = '{1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'h00FF, 1'b1};
        vecs[3] = '{1'b1, 16'hA5C3, 1'b1, 16'h0102, 1'b0};
        vecs[4] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 16'hFFFF, 1'b1, 16'h8001, 1'b1};

        repeat (3) @(posedge CLK);
        #1;
        check("rst ready0", REQ0_READY, 1);
        check("rst ready1", REQ1_READY, 1);
        check("rst tx_start", TX_START, 0);
        check("rst tx_data", TX_DATA, 8'h00);
        check("rst grant", GRANT, 0);
        check("rst busy", BUSY, 0);
        check("rst err", ERR, 0);
        @(negedge CLK);
        RESET = 1'b1;

        // Table: arbitration order and byte serialisation
        done_delay = 2;
        for (int i = 0; i < 6; i++) begin
            drive_pair(vecs[i]);
            if (vecs[i].v0 && vecs[i].v1) begin
                if (vecs[i].first) begin add_frame(1, vecs[i].d1); add_frame(0, vecs[i].d0); end
                else               begin add_frame(0, vecs[i].d0); add_frame(1, vecs[i].d1); end
            end else if (vecs[i].v0) add_frame(0, vecs[i].d0);
            else                     add_frame(1, vecs[i].d1);
            wait_idle($sformatf("vec%0d", i));
            compare_frames($sformatf("vec%0d", i));
        end

        // Single word: latency, stable data in WAIT, byte gap
        done_delay = 3;
        add_frame(0, 16'hBEEF);
        @(negedge CLK);
        REQ0_VALID = 1'b1; REQ0_DATA = 16'hBEEF;
        @(posedge CLK);
        #1;
        acc = cyc;
        REQ0_VALID = 1'b0;
        check("single ready_drop", REQ0_READY, 0);
        check("single no_early_start", TX_START, 0);
        @(posedge CLK);
        #1;
        check("single start", TX_START, 1);
        check("single first_byte", TX_DATA, exp_b[0]);
        check("single busy", BUSY, 1);
        @(posedge CLK);
        #1;
        check("single wait_start_low", TX_START, 0);
        check("single wait_data_held", TX_DATA, exp_b[0]);
        wait_idle("single");
        check("single grant", GRANT, 0);
        if (cap_c.size() >= 2) begin
            check("single latency", cap_c[0] - acc, 1);
            check("single gap", cap_c[1] - cap_c[0], done_delay + 1);
        end
        compare_frames("single");

        // Back-pressure on requester 1
        done_delay = 4;
        push(1, 16'h3141);
        push(1, 16'h5926);
        @(negedge CLK);
        check("bp ready_low", REQ1_READY, 0);
        push(1, 16'h5358);
        add_frame(1, 16'h3141);
        add_frame(1, 16'h5926);
        add_frame(1, 16'h5358);
        wait_idle("bp");
        compare_frames("bp");

        // Watchdog abort on the first byte, next word sent normally
        auto_done = 1'b0;
        done_delay = 2;
        push(0, 16'h1234);
        push(0, 16'h5678);
        auto_done = 1'b1;
        ok = 1'b0;
        err_cyc = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge CLK);
            if (ERR) begin ok = 1'b1; err_cyc = cyc; end
        end
        if (!ok) fail_now("wd err_rise");
        check("wd busy_after_abort", BUSY, 0);
        if (cap_c.size() >= 1) check("wd abort_cycle", err_cyc - cap_c[0], 21);
        add_frame(0, 16'h1234);
        while (exp_b.size() > 1) begin void'(exp_b.pop_back()); void'(exp_g.pop_back()); end
        add_frame(0, 16'h5678);
        wait_idle("wd");
        compare_frames("wd");
        check("wd err_sticky", ERR, 1);

        // Reset in the middle of a frame with another word buffered
        done_delay = 3;
        push(0, 16'hCAFE);
        push(1, 16'hBABE);
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge CLK);
            if (cap_b.size() >= 2) ok = 1'b1;
        end
        if (!ok) fail_now("rstmid second_byte");
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("rstmid busy", BUSY, 0);
        check("rstmid tx_start", TX_START, 0);
        check("rstmid tx_data", TX_DATA, 8'h00);
        check("rstmid grant", GRANT, 0);
        check("rstmid err", ERR, 0);
        check("rstmid ready0", REQ0_READY, 1);
        check("rstmid ready1", REQ1_READY, 1);
        n_cap = cap_b.size();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (30) @(negedge CLK);
        check("rstmid no_stray_start", cap_b.size(), n_cap);
        check("rstmid idle_busy", BUSY, 0);
        check("rstmid idle_ready0", REQ0_READY, 1);
        check("rstmid idle_ready1", REQ1_READY, 1);
        clear_q();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
